// File: rtl/pong_engine_if.sv
// rtl/pong_engine_if.sv - frame-tick, control and game-state bundle between the sync path, the engine and the renderer
//
// Signals:
//   frame_tick                  one-cycle pulse per video frame (start of vblank)
//   left_up/left_down           left paddle controls, active-high levels
//   right_up/right_down         right paddle controls, active-high levels
//   serve                       one-cycle start/restart request
//   ball_x/ball_y               ball top-left corner
//   paddle_l_y/paddle_r_y       paddle top edges
//   score_l/score_r             scores
//   state                       IDLE=0, PLAY=1, POINT=2, OVER=3
//   point_pulse                 one cycle when a point is scored
//   game_over                   high while in OVER
// Modports: master drives the controls and reads the game state, slave is the engine.

interface pong_engine_if #(
    parameter int POS_W   = 10,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               left_up;
    logic               left_down;
    logic               right_up;
    logic               right_down;
    logic               serve;
    logic [POS_W-1:0]   ball_x;
    logic [POS_W-1:0]   ball_y;
    logic [POS_W-1:0]   paddle_l_y;
    logic [POS_W-1:0]   paddle_r_y;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [1:0]         state;
    logic               point_pulse;
    logic               game_over;

    modport master (
        output frame_tick, left_up, left_down, right_up, right_down, serve,
        input  ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r,
               state, point_pulse, game_over
    );

    modport slave (
        input  frame_tick, left_up, left_down, right_up, right_down, serve,
        output ball_x, ball_y, paddle_l_y, paddle_r_y, score_l, score_r,
               state, point_pulse, game_over
    );
endinterface

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong game-state engine: ball, paddles, collisions, scoring, serve delay, game over
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   bus      pong_engine_if.slave (frame_tick, paddle controls, serve in; positions, scores,
//            state, point_pulse, game_over out; all outputs registered)
// Build option:
//   PONG_AI_EN  when defined the right paddle tracks the ball and ignores right_up/right_down.

module pong_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int POS_W       = 10,
    parameter int PADDLE_X    = 32,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_SPEED  = 4,
    parameter int SCORE_W     = 4,
    parameter int SCORE_MAX   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic          clk,
    input  logic          rst,
    pong_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Two spare bits so every sum of a coordinate and a constant fits without wrapping.
    localparam int WW = POS_W + 2;
    typedef logic [WW-1:0] wide_t;

    localparam int CNT_W = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);

    localparam logic [POS_W-1:0] CX       = POS_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] CY       = POS_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] P_MID    = POS_W'((V_RES - PADDLE_H) / 2);
    localparam logic [POS_W-1:0] B_MAX_Y  = POS_W'(V_RES - BALL_SIZE);
    localparam logic [POS_W-1:0] FL       = POS_W'(PADDLE_X + PADDLE_W);
    localparam logic [POS_W-1:0] FR_BALL  = POS_W'(H_RES - PADDLE_X - PADDLE_W - BALL_SIZE);
    localparam logic [POS_W-1:0] STEP     = POS_W'(PADDLE_STEP);
    localparam logic [POS_W-1:0] SPD      = POS_W'(BALL_SPEED);
    localparam logic [POS_W-1:0] P_MAX    = POS_W'(V_RES - PADDLE_H);

    localparam wide_t W_FL     = wide_t'(PADDLE_X + PADDLE_W);
    localparam wide_t W_FR     = wide_t'(H_RES - PADDLE_X - PADDLE_W);
    localparam wide_t W_HRES   = wide_t'(H_RES);
    localparam wide_t W_VRES   = wide_t'(V_RES);
    localparam wide_t W_SIZE   = wide_t'(BALL_SIZE);
    localparam wide_t W_SPD    = wide_t'(BALL_SPEED);
    localparam wide_t W_PH     = wide_t'(PADDLE_H);
    localparam wide_t W_STEP   = wide_t'(PADDLE_STEP);
    localparam wide_t W_PMAX   = wide_t'(V_RES - PADDLE_H);

    localparam logic [SCORE_W-1:0] S_MAX = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] S_ONE = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   DELAY = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [POS_W-1:0]   bx_q, bx_d, by_q, by_d;
    logic [POS_W-1:0]   pl_q, pl_d, pr_q, pr_d;
    logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
    logic               dx_q, dx_d;     // 1 = moving right
    logic               dy_q, dy_d;     // 1 = moving down
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;

    logic               point_l, point_r;
    logic [SCORE_W-1:0] new_score;
    logic               r_up, r_dn;

    wide_t bx_w, by_w, pl_w, pr_w;
    logic  ov_l, ov_r;

    function automatic wide_t wz(input logic [POS_W-1:0] v);
        return wide_t'(v);
    endfunction

    // Paddle step with clamping; the limit is tested before subtracting so y never wraps.
    function automatic logic [POS_W-1:0] paddle_move(input logic [POS_W-1:0] y,
                                                     input logic up, input logic dn);
        logic [POS_W-1:0] r;
        r = y;
        if (up && !dn) begin
            r = (wz(y) < W_STEP) ? '0 : y - STEP;
        end else if (dn && !up) begin
            r = (wz(y) + W_STEP > W_PMAX) ? P_MAX : y + STEP;
        end
        return r;
    endfunction

    assign bx_w = wz(bx_q);
    assign by_w = wz(by_q);
    assign pl_w = wz(pl_q);
    assign pr_w = wz(pr_q);

    // Vertical overlap of the ball with each paddle, using positions before this frame's update.
    assign ov_l = (by_w + W_SIZE > pl_w) && (by_w < pl_w + W_PH);
    assign ov_r = (by_w + W_SIZE > pr_w) && (by_w < pr_w + W_PH);

`ifdef PONG_AI_EN
    localparam wide_t W_HALF_B = wide_t'(BALL_SIZE / 2);
    localparam wide_t W_HALF_P = wide_t'(PADDLE_H / 2);
    localparam wide_t W_DEAD   = wide_t'(4);

    wide_t ai_bc, ai_pc;
    assign ai_bc = by_w + W_HALF_B;
    assign ai_pc = pr_w + W_HALF_P;
    // Dead band around the paddle centre keeps the paddle from dithering.
    assign r_up  = (ai_bc + W_DEAD < ai_pc);
    assign r_dn  = (ai_bc > ai_pc + W_DEAD);
`else
    assign r_up  = bus.right_up;
    assign r_dn  = bus.right_down;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bx_q    <= CX;
            by_q    <= CY;
            pl_q    <= P_MID;
            pr_q    <= P_MID;
            sl_q    <= '0;
            sr_q    <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        pl_d      = pl_q;
        pr_d      = pr_q;
        sl_d      = sl_q;
        sr_d      = sr_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        point_l   = 1'b0;
        point_r   = 1'b0;
        new_score = '0;

        if (bus.frame_tick && state_q != OVER) begin
            pl_d = paddle_move(pl_q, bus.left_up, bus.left_down);
            pr_d = paddle_move(pr_q, r_up, r_dn);
        end

        case (state_q)
            IDLE: begin
                // serve wins over a coinciding frame_tick: the ball stays put this frame.
                if (bus.serve) begin
                    state_d = PLAY;
                    bx_d    = CX;
                    by_d    = CY;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end

            PLAY: begin
                if (bus.frame_tick) begin
                    if (!dy_q && by_w < W_SPD) begin
                        by_d = '0;
                        dy_d = 1'b1;
                    end else if (dy_q && by_w + W_SIZE + W_SPD > W_VRES) begin
                        by_d = B_MAX_Y;
                        dy_d = 1'b0;
                    end else if (dy_q) begin
                        by_d = by_q + SPD;
                    end else begin
                        by_d = by_q - SPD;
                    end

                    if (!dx_q) begin
                        if (bx_w >= W_FL && bx_w < W_FL + W_SPD && ov_l) begin
                            bx_d = FL;
                            dx_d = 1'b1;
                        end else if (bx_w < W_SPD) begin
                            point_r = 1'b1;
                        end else begin
                            bx_d = bx_q - SPD;
                        end
                    end else begin
                        if (bx_w + W_SIZE <= W_FR && bx_w + W_SIZE + W_SPD > W_FR && ov_r) begin
                            bx_d = FR_BALL;
                            dx_d = 1'b0;
                        end else if (bx_w + W_SIZE + W_SPD > W_HRES) begin
                            point_l = 1'b1;
                        end else begin
                            bx_d = bx_q + SPD;
                        end
                    end

                    if (point_l || point_r) begin
                        new_score = point_l ? sl_q + S_ONE : sr_q + S_ONE;
                        if (point_l) begin
                            sl_d = new_score;
                        end else begin
                            sr_d = new_score;
                        end
                        pulse_d = 1'b1;
                        bx_d    = CX;
                        by_d    = CY;
                        // Next serve heads toward the player who conceded.
                        dx_d    = point_l;
                        dy_d    = 1'b1;
                        if (new_score == S_MAX) begin
                            state_d = OVER;
                        end else begin
                            state_d = POINT;
                            cnt_d   = DELAY;
                        end
                    end
                end
            end

            POINT: begin
                // Resumes on the frame that would take the counter to zero,
                // so the freeze lasts exactly SERVE_DELAY frames.
                if (bus.frame_tick) begin
                    if (cnt_q <= C_ONE) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - C_ONE;
                    end
                end
            end

            OVER: begin
                if (bus.serve) begin
                    state_d = PLAY;
                    sl_d    = '0;
                    sr_d    = '0;
                    bx_d    = CX;
                    by_d    = CY;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end
        endcase
    end

    assign bus.ball_x      = bx_q;
    assign bus.ball_y      = by_q;
    assign bus.paddle_l_y  = pl_q;
    assign bus.paddle_r_y  = pr_q;
    assign bus.score_l     = sl_q;
    assign bus.score_r     = sr_q;
    assign bus.state       = state_q;
    assign bus.point_pulse = pulse_q;
    assign bus.game_over   = (state_q == OVER);

endmodule
